tr_step_gen: RTL
================

# tr_step_gen

Tracking-mode stepper drive controller, second generation. Each ADC sample sets the distance between the ADC position `x` and the table target `x0`. From that distance the block picks a step period with a saturated piecewise-linear profile. An enable/deadzone hysteresis FSM decides when the motor drives. Unlike the first generation, the block produces the `drv_step` pulse train itself, with programmable pulse width, a direction-setup guard on reversal, and a running step counter. Everything runs synchronously in the `clk` domain.

## Interface
- `WIDTH_IN`, 12: width of `x0`.
- `WIDTH_WORK`, 16: width of `x`, `dx1`, `dx2`, `F1`, `F2`, `k`, `period`.
- `DEADZONE`, 50: hysteresis threshold, in position LSBs.
- `PULSE_W`, 4: `drv_step` high time, in clk cycles (≥1).
- `DIR_SETUP`, 8: clk cycles between a `drv_dir` change and the next step rising edge.
- `MIN_PERIOD`, 10: floor on the step period (must be > `PULSE_W`).
- `CNT_W`, 32: width of `step_cnt`.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `data_valid`  in  1  single-cycle strobe; new `x` is valid this cycle.
- `tr_mode_enable`  in  1  tracking-mode enable, level.
- `x0`  in  `WIDTH_IN`  target position, zero-extended to `WIDTH_WORK`.
- `x`  in  `WIDTH_WORK`  measured position from the ADC.
- `dx1`, `dx2`  in  `WIDTH_WORK`  profile breakpoints; require `DEADZONE` < `dx1` < `dx2`.
- `F1`, `F2`  in  `WIDTH_WORK`  slow and fast periods; require `F1` ≥ `F2`.
- `k`  in  `WIDTH_WORK`  ramp slope, in clk cycles per LSB.
- `period`  out  `WIDTH_WORK`  latched step period. Reset value 0.
- `drv_step`  out  1  step pulse. Reset value 0.
- `drv_dir`  out  1  1 when `x` ≤ `x0`, 0 otherwise. Reset value 1.
- `drv_enable`  out  1  motor enable. Reset value 0.
- `step_cnt`  out  `CNT_W`  number of steps issued, wraps. Reset value 0.
- `state`  out  2  FSM state, for debug. Reset value IDLE.

## Operation
- Distance and sign:
  - If `x` ≤ zext(`x0`): `dx` = `x0` − `x`, `dir_req` = 1.
  - Else: `dx` = `x` − `x0`, `dir_req` = 0.
- Profile:
  - `dx` ≥ `dx2`: period = `F2`.
  - `dx1` ≤ `dx` < `dx2`: period = `F1` − `k`·(`dx` − `dx1`). The product is computed at 2·`WIDTH_WORK` bits. Any result below `F2`, including an underflow, saturates to `F2`.
  - `dx` < `dx1`: period = `F1`.
  - After the profile, any period below `MIN_PERIOD` is raised to `MIN_PERIOD`.
- On `data_valid`, the block registers `dx_q`, `dir_q` and `period`. The FSM, the reversal logic and the step generator use only these registered values.
- FSM states are IDLE, TRACK and HOLD:
  - IDLE→TRACK when `tr_mode_enable`=1.
  - TRACK→HOLD when `dx_q`=0.
  - HOLD→TRACK when `dx_q` ≥ `DEADZONE`.
  - Any state→IDLE when `tr_mode_enable`=0. This takes priority over every other transition.
  - `drv_enable` is 1 only in TRACK, registered.
- Step generator:
  - In TRACK, `cnt` increments every clk.
  - When `cnt` ≥ `period`−1 and no reversal is pending: `drv_step` goes high for `PULSE_W` cycles, `cnt` returns to 0, and `step_cnt` increments by 1.
  - Outside TRACK, `cnt` is held at 0.
  - A pulse already in progress always completes its `PULSE_W` cycles. No runt pulses.
- Reversal:
  - If `dir_q` ≠ `drv_dir`, step issue is blocked.
  - After any active pulse ends, `drv_dir` takes `dir_q`.
  - Steps stay blocked for `DIR_SETUP` further cycles, then `cnt` restarts from 0.
  - If the direction flips back during the guard, the guard restarts.
- A period change takes effect on the next comparison; `cnt` is not reset. If `cnt` already exceeds the new `period`, a step is issued on the next cycle.

## Timing
- Latency:
  - `data_valid` at cycle t: `period`, `dx_q` and `dir_q` are valid at t+1.
  - FSM reacts at t+2; `drv_enable` follows at t+2.
- First step after entering TRACK: rising edge `period` cycles after the state change. `step_cnt` is registered, updating 1 cycle after the `drv_step` rising edge.
- `data_valid` arriving in the same cycle as `tr_mode_enable` falling: the data is latched and the FSM goes to IDLE.
- `rst` mid-operation: all outputs go to their reset values immediately, and any pulse is truncated.

## Structure
- Package `tr_pkg` holds:
  - the state encoding (IDLE=0, TRACK=1, HOLD=2);
  - the profile-saturation helper function.
- Sub-module `step_pulse_gen` contains the period counter, pulse-width timer, DIR_SETUP guard and `step_cnt`. The top level holds the distance/profile logic, the input registers and the FSM.

## Test plan
All scenarios use default parameters, `dx1`=100, `dx2`=400, `F1`=1000, `F2`=200, `k`=2.
- Far target: `x0`=1000, `x`=1500, `data_valid`, enable=1 → `period`=200, `drv_dir`=0, steps 4 cycles wide every 200 cycles, `step_cnt` +1 per step.
- Ramp: `x`=1200 → `period`=800; `k`=10 with `x`=1350 → `period` saturates to 200.
- Deadzone: `x`=1000 → HOLD, `drv_enable`=0, no steps. `x`=1049 stays in HOLD; `x`=1050 returns to TRACK.
- Reversal while moving: `x` goes from 1500 to 600 → the current pulse finishes, `drv_dir`=1, and the next rising edge comes no earlier than 8 + `period` cycles later.
- Enable drop mid-pulse → the pulse completes its 4 cycles, then IDLE with `drv_enable`=0. `rst` mid-pulse → `drv_step`=0 immediately and `step_cnt`=0.
- MIN_PERIOD clamp: `F2`=3, `x`=1500 → `period`=10.

Source files
------------

// File: rtl/tr_pkg.sv
// rtl/tr_pkg.sv - shared state encoding and profile saturation helper for tr_step_gen
package tr_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // f1 - prod, floored at f2; a negative result (prod > f1) also lands on f2
    function automatic logic [63:0] sat_ramp(input logic [63:0] f1,
                                             input logic [63:0] prod,
                                             input logic [63:0] f2);
        logic [63:0] r;
        if (prod > f1) begin
            r = 64'd0;
        end else begin
            r = f1 - prod;
        end
        return (r < f2) ? f2 : r;
    endfunction

endpackage

// File: rtl/tr_step_gen_step_pulse_gen.sv
// rtl/tr_step_gen_step_pulse_gen.sv - period counter, pulse-width timer, direction guard and step counter
module step_pulse_gen #(
    parameter int WIDTH_WORK = 16,
    parameter int PULSE_W    = 4,
    parameter int DIR_SETUP  = 8,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  track,
    input  logic                  dir_q,
    input  logic [WIDTH_WORK-1:0] period,
    output logic                  drv_step,
    output logic                  drv_dir,
    output logic [CNT_W-1:0]      step_cnt
);

    localparam int GW  = $clog2(DIR_SETUP + 1);
    localparam int PWW = $clog2(PULSE_W + 1);

    logic [WIDTH_WORK-1:0] cnt_d, cnt_q;
    logic [GW-1:0]         guard_d, guard_q;
    logic [PWW-1:0]        width_d, width_q;
    logic                  step_d, step_q;
    logic                  dir_d, dir_r_q;
    logic                  issue_d, issue_q;
    logic [CNT_W-1:0]      step_cnt_d, step_cnt_q;
    logic                  rev_pending, dir_load;

    assign rev_pending = (dir_q != dir_r_q);
    // The direction pin only moves once the pulse pin is low, so no edge shares a pulse
    assign dir_load    = rev_pending && !step_q;

    always_comb begin
        cnt_d      = cnt_q;
        guard_d    = guard_q;
        width_d    = width_q;
        step_d     = step_q;
        dir_d      = dir_r_q;
        issue_d    = 1'b0;
        step_cnt_d = step_cnt_q;

        if (step_q) begin
            if (width_q == '0) begin
                step_d = 1'b0;
            end else begin
                width_d = width_q - 1'b1;
            end
        end

        if (dir_load) begin
            dir_d   = dir_q;
            guard_d = GW'(DIR_SETUP);
        end else if (guard_q != '0) begin
            guard_d = guard_q - 1'b1;
        end

        if (!track || dir_load || (guard_q != '0)) begin
            cnt_d = '0;
        end else if (!rev_pending && !step_q && (cnt_q >= period - 1'b1)) begin
            cnt_d   = '0;
            step_d  = 1'b1;
            width_d = PWW'(PULSE_W - 1);
            issue_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (issue_q) begin
            step_cnt_d = step_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            guard_q    <= '0;
            width_q    <= '0;
            step_q     <= 1'b0;
            dir_r_q    <= 1'b1;
            issue_q    <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            guard_q    <= guard_d;
            width_q    <= width_d;
            step_q     <= step_d;
            dir_r_q    <= dir_d;
            issue_q    <= issue_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign drv_step = step_q;
    assign drv_dir  = dir_r_q;
    assign step_cnt = step_cnt_q;

endmodule

// File: rtl/tr_step_gen.sv
// rtl/tr_step_gen.sv - tracking-mode stepper controller: distance/profile, sample registers, enable/deadzone FSM
module tr_step_gen
    import tr_pkg::*;
#(
    parameter int WIDTH_IN   = 12,
    parameter int WIDTH_WORK = 16,
    parameter int DEADZONE   = 50,
    parameter int PULSE_W    = 4,
    parameter int DIR_SETUP  = 8,
    parameter int MIN_PERIOD = 10,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic                  tr_mode_enable,
    input  logic [WIDTH_IN-1:0]   x0,
    input  logic [WIDTH_WORK-1:0] x,
    input  logic [WIDTH_WORK-1:0] dx1,
    input  logic [WIDTH_WORK-1:0] dx2,
    input  logic [WIDTH_WORK-1:0] F1,
    input  logic [WIDTH_WORK-1:0] F2,
    input  logic [WIDTH_WORK-1:0] k,
    output logic [WIDTH_WORK-1:0] period,
    output logic                  drv_step,
    output logic                  drv_dir,
    output logic                  drv_enable,
    output logic [CNT_W-1:0]      step_cnt,
    output logic [1:0]            state
);

    localparam int PW = 2 * WIDTH_WORK;
    localparam logic [WIDTH_WORK-1:0] MIN_P = WIDTH_WORK'(MIN_PERIOD);
    localparam logic [WIDTH_WORK-1:0] DZ    = WIDTH_WORK'(DEADZONE);

    logic [WIDTH_WORK-1:0] x0_ext, dx, prof, period_new;
    logic [WIDTH_WORK-1:0] dx_d, dx_q, period_d, period_q;
    logic [PW-1:0]         prod;
    logic                  dir_req, dir_d, dir_q;
    logic [1:0]            state_d, state_q;
    logic                  drv_enable_d, drv_enable_q;

    assign x0_ext = WIDTH_WORK'(x0);

    always_comb begin
        if (x <= x0_ext) begin
            dx      = x0_ext - x;
            dir_req = 1'b1;
        end else begin
            dx      = x - x0_ext;
            dir_req = 1'b0;
        end
        prod = PW'(k) * PW'(dx - dx1);
        if (dx >= dx2) begin
            prof = F2;
        end else if (dx >= dx1) begin
            prof = WIDTH_WORK'(sat_ramp(64'(F1), 64'(prod), 64'(F2)));
        end else begin
            prof = F1;
        end
        period_new = (prof < MIN_P) ? MIN_P : prof;

        dx_d     = data_valid ? dx         : dx_q;
        dir_d    = data_valid ? dir_req    : dir_q;
        period_d = data_valid ? period_new : period_q;
    end

    // FSM sees only the registered sample, so it reacts one cycle after the sample lands
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (tr_mode_enable) state_d = ST_TRACK;
            ST_TRACK: if (dx_q == '0)     state_d = ST_HOLD;
            ST_HOLD:  if (dx_q >= DZ)     state_d = ST_TRACK;
            default:  state_d = ST_IDLE;
        endcase
        if (!tr_mode_enable) begin
            state_d = ST_IDLE;
        end
        drv_enable_d = (state_d == ST_TRACK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx_q         <= '0;
            dir_q        <= 1'b1;
            period_q     <= '0;
            state_q      <= ST_IDLE;
            drv_enable_q <= 1'b0;
        end else begin
            dx_q         <= dx_d;
            dir_q        <= dir_d;
            period_q     <= period_d;
            state_q      <= state_d;
            drv_enable_q <= drv_enable_d;
        end
    end

    step_pulse_gen #(
        .WIDTH_WORK (WIDTH_WORK),
        .PULSE_W    (PULSE_W),
        .DIR_SETUP  (DIR_SETUP),
        .CNT_W      (CNT_W)
    ) u_step (
        .clk      (clk),
        .rst      (rst),
        .track    (drv_enable_q),
        .dir_q    (dir_q),
        .period   (period_q),
        .drv_step (drv_step),
        .drv_dir  (drv_dir),
        .step_cnt (step_cnt)
    );

    assign period     = period_q;
    assign drv_enable = drv_enable_q;
    assign state      = state_q;

endmodule
